// File: rtl/branch_pkg.sv
// Shared definitions for the branch-class execute sequencer.
// Latency: n/a (constants, encodings and layout helpers only).
// Backpressure: n/a.
// Contents: opcodes, FSM state codes, control-word layout, pc_fs/alu_fs
// encodings, the safe control word and ARM condition codes.
package branch_pkg;

  // Opcode fields, compared against the top bits of the instruction word
  localparam logic [5:0]  OP_B     = 6'b000101;       // I[31:26]
  localparam logic [5:0]  OP_BL    = 6'b100101;       // I[31:26]
  localparam logic [7:0]  OP_BCOND = 8'b01010100;     // I[31:24]
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;     // I[31:24]
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;     // I[31:24]
  localparam logic [10:0] OP_BR    = 11'b11010110000; // I[31:21]

  // FSM state codes
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LINK = 3'd1;
  localparam logic [2:0] ST_TEST = 3'd2;
  localparam logic [2:0] ST_JUMP = 3'd3;
  localparam logic [2:0] ST_SKIP = 3'd4;
  localparam logic [2:0] ST_JREG = 3'd5;
  localparam logic [2:0] ST_BAD  = 3'd6;

  // Program-counter function select
  localparam logic [1:0] PC_FS_HOLD = 2'b00;
  localparam logic [1:0] PC_FS_INC  = 2'b01; // PC + 4
  localparam logic [1:0] PC_FS_REL  = 2'b10; // PC + 4*K
  localparam logic [1:0] PC_FS_BUS  = 2'b11; // load from databus

  // ALU operation in alu_fs[4:2]; alu_fs[1] inverts B, alu_fs[0] inverts A
  localparam logic [2:0] ALU_OP_AND  = 3'd0;
  localparam logic [2:0] ALU_OP_OR   = 3'd1;
  localparam logic [2:0] ALU_OP_ADD  = 3'd2;
  localparam logic [2:0] ALU_OP_XOR  = 3'd3;
  localparam logic [2:0] ALU_OP_LSL  = 3'd4;
  localparam logic [2:0] ALU_OP_LSR  = 3'd5;
  localparam logic [2:0] ALU_OP_ZERO = 3'd6;
  localparam logic [4:0] ALU_FS_PASS_A = {ALU_OP_OR, 2'b00}; // A | K, with K held at 0
  localparam logic [4:0] ALU_FS_SAFE   = 5'b11111;

  // next_state field of the control word
  localparam logic [1:0] NS_FETCH = 2'b00;
  localparam logic [1:0] NS_EXEC  = 2'b11;

  // Control-word layout, LSB first. The three register fields sit between
  // rf_w and rf_b_en, so every offset above rf_da scales with the RF width.
  localparam int CW_FIXED_W       = 18;
  localparam int CW_ALU_FS_W      = 5;
  localparam int CW_PC_FS_W       = 2;
  localparam int CW_NS_W          = 2;
  localparam int CW_NS_OFS        = 0;
  localparam int CW_STATUS_LD_OFS = 2;
  localparam int CW_PC_IS_OFS     = 3;
  localparam int CW_PC_FS_OFS     = 4;
  localparam int CW_PC_EN_OFS     = 6;
  localparam int CW_RAM_W_OFS     = 7;
  localparam int CW_RAM_EN_OFS    = 8;
  localparam int CW_RF_W_OFS      = 9;
  localparam int CW_RF_DA_OFS     = 10;

  function automatic int cw_rf_sb_ofs(input int aw);   return CW_RF_DA_OFS + aw;         endfunction
  function automatic int cw_rf_sa_ofs(input int aw);   return CW_RF_DA_OFS + 2 * aw;     endfunction
  function automatic int cw_rf_b_en_ofs(input int aw); return CW_RF_DA_OFS + 3 * aw;     endfunction
  function automatic int cw_alu_fs_ofs(input int aw);  return CW_RF_DA_OFS + 3 * aw + 1; endfunction
  function automatic int cw_alu_bs_ofs(input int aw);  return CW_RF_DA_OFS + 3 * aw + 6; endfunction
  function automatic int cw_alu_en_ofs(input int aw);  return CW_RF_DA_OFS + 3 * aw + 7; endfunction

  // Idle control word at the default 5-bit register address width
  localparam logic [32:0] SAFE_CW = {1'b0, 1'b1, ALU_FS_SAFE, 1'b0,
                                     5'd31, 5'd31, 5'd31,
                                     1'b0, 1'b0, 1'b0, 1'b0,
                                     PC_FS_HOLD, 1'b0, 1'b0, NS_FETCH};

  // ARM condition codes
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates an ARM condition code against the stored NZCV flags.
// Latency: combinational.
// Backpressure: none.
// Ports: cond[3:0] condition code, flags[3:0] {V,C,N,Z}, taken result.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic z, n, c, v;

  always_comb begin
    z = flags[0];
    n = flags[1];
    c = flags[2];
    v = flags[3];
    taken = 1'b1;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~(c & ~z);
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = ~(~z & (n == v));
      COND_AL, COND_NV: taken = 1'b1;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle execute-stage sequencer for B, BL, B.cond, CBZ, CBNZ and BR.
// Latency: start to done 1 cycle (B, B.cond, BR, illegal) or 2 cycles (BL, CBZ/CBNZ).
// Backpressure: none; start is only accepted in IDLE, requester waits for busy=0.
// Ports: clock/reset_n; start + I (instruction) + status {alu_zero,V,C,N,Z} in;
// busy, done, illegal strobes and the control word cw + constant K out.
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int RF_AW    = 5,
  parameter int LINK_REG = 30,
  parameter int ZERO_REG = 31
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [31:0]                     I,
  input  logic [4:0]                      status,
  output logic                            busy,
  output logic                            done,
  output logic                            illegal,
  output logic [CW_FIXED_W+3*RF_AW-1:0]   cw,
  output logic [DATA_W-1:0]               K
);

  localparam logic [RF_AW-1:0] ZERO_IDX = RF_AW'(ZERO_REG);
  localparam logic [RF_AW-1:0] LINK_IDX = RF_AW'(LINK_REG);

  localparam int RF_SB_OFS   = cw_rf_sb_ofs(RF_AW);
  localparam int RF_SA_OFS   = cw_rf_sa_ofs(RF_AW);
  localparam int RF_B_EN_OFS = cw_rf_b_en_ofs(RF_AW);
  localparam int ALU_FS_OFS  = cw_alu_fs_ofs(RF_AW);
  localparam int ALU_BS_OFS  = cw_alu_bs_ofs(RF_AW);
  localparam int ALU_EN_OFS  = cw_alu_en_ofs(RF_AW);

  logic [2:0]  state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        cond_taken;

  // Condition is judged against the flags present in the start cycle
  branch_cond_eval u_cond (
    .cond  (I[3:0]),
    .flags (status[3:0]),
    .taken (cond_taken)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ir_d = I;
          if (I[31:26] == OP_B)                                 state_d = ST_JUMP;
          else if (I[31:26] == OP_BL)                           state_d = ST_LINK;
          else if (I[31:24] == OP_BCOND)                        state_d = cond_taken ? ST_JUMP : ST_SKIP;
          else if (I[31:24] == OP_CBZ || I[31:24] == OP_CBNZ)   state_d = ST_TEST;
          else if (I[31:21] == OP_BR)                           state_d = ST_JREG;
          else                                                  state_d = ST_BAD;
        end
      end
      ST_LINK: state_d = ST_JUMP;
      // status[4] reflects the register read issued during this cycle
      ST_TEST: begin
        if ((ir_q[31:24] == OP_CBZ) == status[4]) state_d = ST_JUMP;
        else                                      state_d = ST_SKIP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Moore output decode: fields start from the safe word and each state
  // overrides only what it drives.
  logic             alu_en, alu_bs, rf_b_en, rf_w, ram_en, ram_w, pc_en, pc_is, status_ld;
  logic [4:0]       alu_fs;
  logic [RF_AW-1:0] rf_sa, rf_sb, rf_da;
  logic [1:0]       pc_fs, next_st;
  logic             imm26_form;

  always_comb begin
    alu_en     = 1'b0;
    alu_bs     = 1'b1;
    alu_fs     = ALU_FS_SAFE;
    rf_b_en    = 1'b0;
    rf_sa      = ZERO_IDX;
    rf_sb      = ZERO_IDX;
    rf_da      = ZERO_IDX;
    rf_w       = 1'b0;
    ram_en     = 1'b0;
    ram_w      = 1'b0;
    pc_en      = 1'b0;
    pc_fs      = PC_FS_HOLD;
    pc_is      = 1'b0;
    status_ld  = 1'b0;
    next_st    = NS_FETCH;
    K          = '0;
    imm26_form = (ir_q[31:26] == OP_B) || (ir_q[31:26] == OP_BL);
    case (state_q)
      // PC+4 is put on the bus and written to the link register
      ST_LINK: begin
        pc_en   = 1'b1;
        rf_da   = LINK_IDX;
        rf_w    = 1'b1;
        next_st = NS_EXEC;
      end
      ST_TEST: begin
        rf_sa   = RF_AW'(ir_q[4:0]);
        alu_fs  = ALU_FS_PASS_A;
        next_st = NS_EXEC;
      end
      ST_JUMP: begin
        pc_fs = PC_FS_REL;
        if (imm26_form) K = {{(DATA_W-26){ir_q[25]}}, ir_q[25:0]};
        else            K = {{(DATA_W-19){ir_q[23]}}, ir_q[23:5]};
      end
      ST_SKIP: pc_fs = PC_FS_INC;
      ST_JREG: begin
        rf_sa  = RF_AW'(ir_q[9:5]);
        alu_en = 1'b1;
        alu_fs = ALU_FS_PASS_A;
        pc_fs  = PC_FS_BUS;
      end
      default: ;
    endcase
  end

  always_comb begin
    cw = '0;
    cw[ALU_EN_OFS]                       = alu_en;
    cw[ALU_BS_OFS]                       = alu_bs;
    cw[ALU_FS_OFS +: CW_ALU_FS_W]        = alu_fs;
    cw[RF_B_EN_OFS]                      = rf_b_en;
    cw[RF_SA_OFS +: RF_AW]               = rf_sa;
    cw[RF_SB_OFS +: RF_AW]               = rf_sb;
    cw[CW_RF_DA_OFS +: RF_AW]            = rf_da;
    cw[CW_RF_W_OFS]                      = rf_w;
    cw[CW_RAM_EN_OFS]                    = ram_en;
    cw[CW_RAM_W_OFS]                     = ram_w;
    cw[CW_PC_EN_OFS]                     = pc_en;
    cw[CW_PC_FS_OFS +: CW_PC_FS_W]       = pc_fs;
    cw[CW_PC_IS_OFS]                     = pc_is;
    cw[CW_STATUS_LD_OFS]                 = status_ld;
    cw[CW_NS_OFS +: CW_NS_W]             = next_st;
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_JUMP) || (state_q == ST_SKIP) ||
                   (state_q == ST_JREG) || (state_q == ST_BAD);
  assign illegal = (state_q == ST_BAD);

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] I;
  logic [4:0]  status;
  logic        busy, done, illegal;
  logic [32:0] cw;
  logic [63:0] K;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  branch_sequencer #(
    .DATA_W(64), .RF_AW(5), .LINK_REG(30), .ZERO_REG(31)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .I(I), .status(status),
    .busy(busy), .done(done), .illegal(illegal), .cw(cw), .K(K)
  );

  typedef struct packed {
    logic [32:0] cw;
    logic [63:0] k;
    logic        busy;
    logic        done;
    logic        illegal;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  localparam logic [4:0] XZR      = 5'd31;
  localparam logic [4:0] LR       = 5'd30;
  localparam logic [4:0] FS_SAFE  = 5'b11111;
  localparam logic [4:0] FS_PASSA = 5'b00100;

  // Control word in field order {alu_en, alu_bs, alu_fs, rf_b_en, sa, sb, da,
  // rf_w, ram_en, ram_w, pc_en, pc_fs, pc_is, status_ld, next_state}
  function automatic logic [32:0] mk_cw(
    input logic alu_en, alu_bs, input logic [4:0] alu_fs, input logic rf_b_en,
    input logic [4:0] sa, sb, da, input logic rf_w, ram_en, ram_w, pc_en,
    input logic [1:0] pc_fs, input logic pc_is, st_ld, input logic [1:0] ns);
    return {alu_en, alu_bs, alu_fs, rf_b_en, sa, sb, da, rf_w, ram_en, ram_w,
            pc_en, pc_fs, pc_is, st_ld, ns};
  endfunction

  function automatic exp_t mk_exp(input logic [32:0] c, input logic [63:0] k,
                                  input logic b, input logic d, input logic il);
    exp_t e;
    e.cw = c; e.k = k; e.busy = b; e.done = d; e.illegal = il;
    return e;
  endfunction

  function automatic exp_t x_idle();
    return mk_exp(mk_cw(1'b0, 1'b1, FS_SAFE, 1'b0, XZR, XZR, XZR, 1'b0, 1'b0, 1'b0, 1'b0,
                        2'b00, 1'b0, 1'b0, 2'b00), 64'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t x_link();
    return mk_exp(mk_cw(1'b0, 1'b1, FS_SAFE, 1'b0, XZR, XZR, LR, 1'b1, 1'b0, 1'b0, 1'b1,
                        2'b00, 1'b0, 1'b0, 2'b11), 64'd0, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic exp_t x_jump(input logic [63:0] k);
    return mk_exp(mk_cw(1'b0, 1'b1, FS_SAFE, 1'b0, XZR, XZR, XZR, 1'b0, 1'b0, 1'b0, 1'b0,
                        2'b10, 1'b0, 1'b0, 2'b00), k, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic exp_t x_skip();
    return mk_exp(mk_cw(1'b0, 1'b1, FS_SAFE, 1'b0, XZR, XZR, XZR, 1'b0, 1'b0, 1'b0, 1'b0,
                        2'b01, 1'b0, 1'b0, 2'b00), 64'd0, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic exp_t x_test(input logic [4:0] rs);
    return mk_exp(mk_cw(1'b0, 1'b1, FS_PASSA, 1'b0, rs, XZR, XZR, 1'b0, 1'b0, 1'b0, 1'b0,
                        2'b00, 1'b0, 1'b0, 2'b11), 64'd0, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic exp_t x_jreg(input logic [4:0] rn);
    return mk_exp(mk_cw(1'b1, 1'b1, FS_PASSA, 1'b0, rn, XZR, XZR, 1'b0, 1'b0, 1'b0, 1'b0,
                        2'b11, 1'b0, 1'b0, 2'b00), 64'd0, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic exp_t x_bad();
    return mk_exp(mk_cw(1'b0, 1'b1, FS_SAFE, 1'b0, XZR, XZR, XZR, 1'b0, 1'b0, 1'b0, 1'b0,
                        2'b00, 1'b0, 1'b0, 2'b00), 64'd0, 1'b1, 1'b1, 1'b1);
  endfunction

  // Reference ARM condition: base test from cond[3:1], cond[0] inverts (except 111x)
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic z, n, cy, v, r;
    z = f[0]; n = f[1]; cy = f[2]; v = f[3];
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cy;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cy & ~z;
      3'd5:    r = (n == v);
      3'd6:    r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (c[3:1] != 3'd7 && c[0]) r = ~r;
    return r;
  endfunction

  task automatic push(input string tag, input exp_t e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input string fld,
                     input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
    end
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_underflow observed=0 expected=nonzero");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, "cw",      64'(cw),      64'(e.cw));
      chk(t, "K",       K,            e.k);
      chk(t, "busy",    64'(busy),    64'(e.busy));
      chk(t, "done",    64'(done),    64'(e.done));
      chk(t, "illegal", 64'(illegal), 64'(e.illegal));
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_out();
    start = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [4:0] st);
    start  = 1'b1;
    I      = instr;
    status = st;
  endtask

  initial begin
    logic [31:0] ins;
    logic [31:0] br_x17;
    logic [3:0]  fl;
    logic        tk;

    reset_n = 1'b0; start = 1'b0; I = 32'd0; status = 5'd0;
    br_x17 = {11'b11010110000, 5'b11111, 6'b000000, 5'd17, 5'b00000};

    #3;
    push("reset", x_idle());
    check_out();
    #9 reset_n = 1'b1;
    push("idle0", x_idle());
    step();

    // BL with imm26 = -2
    ins = {6'b100101, 26'h3FFFFFE};
    issue(ins, 5'd0);
    push("bl_link", x_link());
    push("bl_jump", x_jump(64'hFFFF_FFFF_FFFF_FFFE));
    push("bl_idle", x_idle());
    step(); step(); step();

    // Plain B, positive offset
    ins = {6'b000101, 26'h0000100};
    issue(ins, 5'd0);
    push("b_jump", x_jump(64'h100));
    push("b_idle", x_idle());
    step(); step();

    // B.GT with Z=0 N=1 V=1 (taken), negative imm19
    ins = {8'h54, 19'h7FFF0, 1'b0, 4'hC};
    issue(ins, 5'b01010);
    push("bgt_jump", x_jump(64'hFFFF_FFFF_FFFF_FFF0));
    push("bgt_idle", x_idle());
    step(); step();

    // Same with Z=1 (not taken)
    issue(ins, 5'b01011);
    push("bgt_skip", x_skip());
    push("bgt_idle2", x_idle());
    step(); step();

    // All condition codes with random flags
    for (int rep = 0; rep < 2; rep++) begin
      for (int c = 0; c < 16; c++) begin
        fl  = 4'($urandom_range(0, 15));
        ins = {8'h54, 19'h00003, 1'b0, 4'(c)};
        tk  = cond_ok(4'(c), fl);
        issue(ins, {1'b0, fl});
        if (tk) push($sformatf("bcond%0d_jump", c), x_jump(64'd3));
        else    push($sformatf("bcond%0d_skip", c), x_skip());
        push($sformatf("bcond%0d_idle", c), x_idle());
        step(); step();
      end
    end

    // CBNZ X5, register nonzero; start during TEST and during done is dropped
    ins = {8'hB5, 19'h00040, 5'd5};
    issue(ins, 5'b10000);
    push("cbnz_test", x_test(5'd5));
    push("cbnz_jump", x_jump(64'h40));
    push("cbnz_idle", x_idle());
    push("cbnz_idle2", x_idle());
    step();
    status = 5'b00000;
    start = 1'b1; I = br_x17;
    step();
    start = 1'b1; I = {6'b000101, 26'h0000010};
    step();
    step();

    // CBNZ X5, register zero -> skip
    issue(ins, 5'b00000);
    push("cbnz_test_z", x_test(5'd5));
    push("cbnz_skip", x_skip());
    push("cbnz_idle3", x_idle());
    step();
    status = 5'b10000;
    step(); step();

    // CBZ X3, register zero -> taken
    ins = {8'hB4, 19'h00001, 5'd3};
    issue(ins, 5'b00000);
    push("cbz_test", x_test(5'd3));
    push("cbz_jump", x_jump(64'd1));
    push("cbz_idle", x_idle());
    step();
    status = 5'b10000;
    step(); step();

    // BR X17
    issue(br_x17, 5'd0);
    push("br_jreg", x_jreg(5'd17));
    push("br_idle", x_idle());
    step(); step();

    // ADD is not a branch
    issue(32'h8B00_0000, 5'd0);
    push("add_bad", x_bad());
    push("add_idle", x_idle());
    step(); step();

    // Async reset in the middle of BL
    ins = {6'b100101, 26'h0000020};
    issue(ins, 5'd0);
    push("rst_link", x_link());
    step();
    #2 reset_n = 1'b0;
    #1;
    push("rst_async", x_idle());
    check_out();
    @(posedge clock);
    #2 reset_n = 1'b1;
    push("rst_after", x_idle());
    push("rst_after2", x_idle());
    step(); step();

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Multi-cycle execute-stage sequencer for all branch-class instructions: B, BL, B.cond, CBZ, CBNZ and BR.
- Successor to the single-cycle per-instruction decoders. Parametrised in data width, register-file address width and link register.
- Adds an FSM so that BL link-write, CBZ/CBNZ register test and BR register jump each take their own cycles.
- Sits in the control unit. The decode mux hands it the instruction. It returns the 33-bit control word, the K constant and done/illegal strobes.

Parameters:
- DATA_W, 64, datapath width; width of K.
- RF_AW, 5, register-file address width.
- LINK_REG, 30, register written by BL.
- ZERO_REG, 31, don't-care/zero register index used in idle words.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; I is valid this cycle.
- I  in  32  instruction word.
- status  in  5  [0]Z [1]N [2]C [3]V are the stored flags; [4] is the live ALU-result-zero flag.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse on the final cycle of a sequence.
- illegal  out  1  one-cycle pulse when the opcode is not a branch.
- cw  out  33  control word {alu_en, alu_bs, alu_fs[4:0], rf_b_en, rf_sa, rf_sb, rf_da, rf_w, ram_en, ram_w, pc_en, pc_fs[1:0], pc_is, status_ld, next_state[1:0]}. Register fields are RF_AW wide; 33 bits at RF_AW=5.
- K  out  DATA_W  sign-extended offset.

Behaviour:
- Encodings:
  - pc_fs: 00 hold, 01 PC+4, 10 PC+4*K, 11 load from databus.
  - alu_fs[4:2]: and, or, add, xor, lsl, lsr, zero, zero. alu_fs[1] inverts B; alu_fs[0] inverts A.
- SAFE_CW:
  - alu_en=0, alu_bs=1, alu_fs=11111, rf_b_en=0, rf_sa=rf_sb=rf_da=ZERO_REG.
  - rf_w=0, ram_en=0, ram_w=0, pc_en=0, pc_fs=00, pc_is=0, status_ld=0, next_state=00.
- cw, K, done and illegal are Moore outputs, decoded from the state register and the latched instruction IR.
- Reset (async, any time, including mid-sequence):
  - state=IDLE, IR=0, cw=SAFE_CW, K=0, busy=done=illegal=0.
  - No partial write completes after reset assertion.
- IDLE:
  - cw=SAFE_CW.
  - On start, latch I into IR and branch on opcode:
    - B (I[31:26]=000101) -> JUMP.
    - BL (100101) -> LINK.
    - B.cond (I[31:24]=01010100): evaluate cond I[3:0] against status[3:0] this cycle; taken -> JUMP, else SKIP.
    - CBZ (10110100) or CBNZ (10110101) -> TEST.
    - BR (I[31:21]=11010110000) -> JREG.
    - Anything else -> BAD.
  - start is ignored when state != IDLE.
- LINK (1 cycle):
  - pc_en=1, so PC+4 drives the bus.
  - rf_da=LINK_REG, rf_w=1, pc_fs=00.
  - Next state JUMP.
- TEST (1 cycle):
  - rf_sa=I[4:0], alu_en=0, alu_bs=1, K=0, alu_fs=00100 (A or 0).
  - Sample status[4] at the clock edge.
  - CBZ and zero, or CBNZ and nonzero -> JUMP; otherwise SKIP.
- JUMP (1 cycle):
  - pc_fs=10.
  - K=sext(I[25:0]) for B/BL; K=sext(I[23:5]) for B.cond/CBZ/CBNZ.
  - done=1, next_state=00. Next state IDLE.
- SKIP (1 cycle): pc_fs=01, K=0, done=1. Next state IDLE.
- JREG (1 cycle):
  - rf_sa=I[9:5], alu_en=1, alu_bs=1, K=0, alu_fs=00100, pc_fs=11.
  - done=1. Next state IDLE.
- BAD (1 cycle): cw=SAFE_CW, illegal=1, done=1. Next state IDLE.
- next_state field: 11 (stay in execute) in every non-final busy cycle; 00 in IDLE and final cycles.
- K outside the states above is 0.
- Condition evaluation (ARM semantics), cond 0..13:
  - EQ/NE: Z.
  - CS/CC: C.
  - MI/PL: N.
  - VS/VC: V.
  - HI: C & ~Z. LS: the inverse.
  - GE: N==V. LT: the inverse.
  - GT: ~Z & N==V. LE: the inverse.
  - 14 and 15: always taken.
- Latencies, start to done:
  - B: 1 cycle.
  - BL: 2 cycles.
  - B.cond: 1 cycle.
  - CBZ/CBNZ: 2 cycles.
  - BR: 1 cycle.
  - Illegal: 1 cycle.
- A start in the same cycle as done (state != IDLE) is dropped. The requester must wait for busy=0.

Decomposition:
- Shared package branch_pkg holds:
  - opcode constants;
  - the state enum (IDLE, LINK, TEST, JUMP, SKIP, JREG, BAD);
  - cw field widths and offsets;
  - the pc_fs and alu_fs encodings;
  - SAFE_CW;
  - cond-code constants.
- One natural sub-module: branch_cond_eval. It is combinational, takes cond[3:0] and flags[3:0], and outputs taken.

Test Plan:
- BL with imm26=0x3FFFFFE (-2): LINK cycle shows rf_da=30, rf_w=1, pc_en=1. Next cycle JUMP shows pc_fs=10, K=0xFFFF_FFFF_FFFF_FFFE, done=1.
- B.cond GT (cond=1100) with Z=0, N=1, V=1: taken -> JUMP, K=sext(imm19). Repeat with Z=1: SKIP, pc_fs=01, K=0.
- CBNZ X5 with status[4]=0 in the TEST cycle: TEST shows rf_sa=5, next_state=11. Then JUMP with done on cycle 2. Same with status[4]=1: SKIP.
- BR X17: one cycle with rf_sa=17, alu_en=1, pc_fs=11, done=1. busy deasserted the following cycle.
- I=0x8B000000 (ADD): BAD cycle shows illegal=1, done=1, cw=SAFE_CW. No rf_w or pc_en at any point.
- reset_n low during BL LINK: cw=SAFE_CW and busy=0 immediately, without waiting for a clock edge. start asserted while in TEST is ignored: IR is unchanged.
